// File: rtl/sc_ulpi_pkg.sv
// sc_ulpi_pkg: shared ULPI types and constants for the register-access path.
package sc_ulpi_pkg;

  // ULPI TX command codes (upper two bits of a TX CMD byte)
  localparam logic [1:0] ccdSpecial  = 2'b00;
  localparam logic [1:0] ccdTransmit = 2'b01;
  localparam logic [1:0] ccdRegWrite = 2'b10;
  localparam logic [1:0] ccdRegRead  = 2'b11;

  // Default REG_ACK watchdog limit in ULPICLK cycles
  localparam int unsigned ARB_TIMEOUT_DEFAULT = 1023;

  // Register arbiter state
  typedef enum logic [1:0] {
    arbIdle = 2'd0,
    arbWait = 2'd1,
    arbDone = 2'd2
  } arbState_e;

  // One register access as presented to the ULPI controller
  typedef struct packed {
    logic [1:0] ccd;
    logic [5:0] cpd;
    logic [7:0] ead;
    logic [7:0] txd;
  } ulpiRegReq_s;

endpackage

// File: rtl/sc_ulpi_rr_pick.sv
// sc_ulpi_rr_pick: combinational round-robin picker. Searches from ptr+1,
// wrapping modulo NREQ, so the requester at ptr has the lowest priority.
module sc_ulpi_rr_pick #(
  parameter int unsigned NREQ = 3
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [2:0]      ptr_i,
  output logic            vld_o,
  output logic [2:0]      idx_o
);

  logic [7:0] req_pad_c;
  logic [2:0] cand_c;
  logic       found_c;

  // First set request at or after ptr+1 (mod NREQ) wins
  always_comb begin
    req_pad_c = 8'(req_i);
    found_c   = 1'b0;
    idx_o     = ptr_i;
    cand_c    = ptr_i;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand_c = 3'((32'(ptr_i) + i) % NREQ);
      if (!found_c && req_pad_c[cand_c]) begin
        found_c = 1'b1;
        idx_o   = cand_c;
      end
    end
    vld_o = found_c;
  end

endmodule

// File: rtl/sc_ulpi_reg_arb.sv
// sc_ulpi_reg_arb: round-robin arbiter sharing the ULPI register interface
// among NREQ requesters. Optional REG_ACK watchdog built when
// SC_ULPI_REG_ARB_TIMEOUT_EN is defined; otherwise arbWait waits forever
// and RQ_ERR never asserts.
module sc_ulpi_reg_arb
  import sc_ulpi_pkg::*;
#(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic              ULPICLK,
  input  logic              ULPIRST,
  input  logic [NREQ-1:0]   RQ_REQ,
  output logic [NREQ-1:0]   RQ_ACK,
  output logic [NREQ-1:0]   RQ_ERR,
  input  logic [2*NREQ-1:0] RQ_CCD,
  input  logic [6*NREQ-1:0] RQ_CPD,
  input  logic [8*NREQ-1:0] RQ_EXT_ADDR,
  input  logic [8*NREQ-1:0] RQ_TX_DATA,
  output logic [7:0]        RQ_RXD,
  output logic              ARB_BUSY,
  output logic [2:0]        ARB_GNT,
  output logic              REG_REQ,
  input  logic              REG_ACK,
  output logic [1:0]        REG_CCD,
  output logic [5:0]        REG_CPD,
  output logic [7:0]        REG_EXT_ADDR,
  output logic [7:0]        REG_TX_DATA,
  input  logic [7:0]        ULPI_DATA
);

  localparam int unsigned GNT_W = 3;

  arbState_e         state_q;
  logic [GNT_W-1:0]  ptr_q;
  logic [GNT_W-1:0]  gnt_q;
  ulpiRegReq_s       fld_q;
  logic [NREQ-1:0]   ack_q;
  logic [NREQ-1:0]   err_q;
  logic [7:0]        rxd_q;
  logic              busy_q;
  logic              req_q;

  logic              pick_vld_c;
  logic [GNT_W-1:0]  pick_idx_c;
  ulpiRegReq_s       pick_fld_c;
  logic [NREQ-1:0]   gnt_oh_c;
  logic              wdog_expire_c;

  sc_ulpi_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req_i (RQ_REQ),
    .ptr_i (ptr_q),
    .vld_o (pick_vld_c),
    .idx_o (pick_idx_c)
  );

  // Select the candidate winner's request fields
  always_comb begin
    pick_fld_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_idx_c == GNT_W'(i)) begin
        pick_fld_c.ccd = RQ_CCD[i*2 +: 2];
        pick_fld_c.cpd = RQ_CPD[i*6 +: 6];
        pick_fld_c.ead = RQ_EXT_ADDR[i*8 +: 8];
        pick_fld_c.txd = RQ_TX_DATA[i*8 +: 8];
      end
    end
  end

  // One-hot form of the current grant for the completion pulse
  always_comb begin
    gnt_oh_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      gnt_oh_c[i] = (gnt_q == GNT_W'(i));
    end
  end

`ifdef SC_ULPI_REG_ARB_TIMEOUT_EN
  localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);

  logic [WDOG_W-1:0] wdog_q;
  logic [WDOG_W-1:0] wdog_d;

  // Count cycles spent in arbWait; held at zero elsewhere, saturates at TIMEOUT
  always_comb begin
    wdog_d = wdog_q;
    if (state_q != arbWait) begin
      wdog_d = '0;
    end else if (wdog_q != WDOG_W'(TIMEOUT)) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
  end

  // Watchdog counter register
  always_ff @(posedge ULPICLK) begin
    if (ULPIRST) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  // Expires on the edge that completes TIMEOUT cycles of REG_REQ high
  assign wdog_expire_c = (state_q == arbWait) && (wdog_q == WDOG_W'(TIMEOUT - 1));
`else
  logic [15:0] unused_timeout_c;

  assign unused_timeout_c = 16'(TIMEOUT);
  assign wdog_expire_c    = 1'b0;
`endif

  // Arbiter FSM: grant, wait for REG_ACK or watchdog, one-cycle turnaround
  always_ff @(posedge ULPICLK) begin
    if (ULPIRST) begin
      state_q <= arbIdle;
      ptr_q   <= GNT_W'(NREQ - 1);
      gnt_q   <= GNT_W'(NREQ - 1);
      fld_q   <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      rxd_q   <= '0;
      busy_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      ack_q <= '0;
      err_q <= '0;
      case (state_q)
        arbIdle: begin
          if (pick_vld_c) begin
            fld_q   <= pick_fld_c;
            ptr_q   <= pick_idx_c;
            gnt_q   <= pick_idx_c;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= arbWait;
          end
        end
        arbWait: begin
          if (REG_ACK) begin
            req_q   <= 1'b0;
            ack_q   <= gnt_oh_c;
            if (fld_q.ccd == ccdRegRead) begin
              rxd_q <= ULPI_DATA;
            end
            state_q <= arbDone;
          end else if (wdog_expire_c) begin
            req_q   <= 1'b0;
            ack_q   <= gnt_oh_c;
            err_q   <= gnt_oh_c;
            rxd_q   <= '0;
            state_q <= arbDone;
          end
        end
        arbDone: begin
          busy_q  <= 1'b0;
          state_q <= arbIdle;
        end
        default: begin
          state_q <= arbIdle;
        end
      endcase
    end
  end

  assign RQ_ACK       = ack_q;
  assign RQ_ERR       = err_q;
  assign RQ_RXD       = rxd_q;
  assign ARB_BUSY     = busy_q;
  assign ARB_GNT      = gnt_q;
  assign REG_REQ      = req_q;
  assign REG_CCD      = fld_q.ccd;
  assign REG_CPD      = fld_q.cpd;
  assign REG_EXT_ADDR = fld_q.ead;
  assign REG_TX_DATA  = fld_q.txd;

endmodule

// File: tb/tb_sc_ulpi_reg_arb.sv
// tb_sc_ulpi_reg_arb: directed, table-driven bench for sc_ulpi_reg_arb
// (NREQ=3, TIMEOUT=16), with hand sequences for timeout, ack at the limit,
// reset mid-access and fairness.
module tb_sc_ulpi_reg_arb;
  import sc_ulpi_pkg::*;

  logic        ULPICLK = 1'b0;
  logic        ULPIRST;
  logic [2:0]  RQ_REQ;
  logic [2:0]  RQ_ACK;
  logic [2:0]  RQ_ERR;
  logic [5:0]  RQ_CCD;
  logic [17:0] RQ_CPD;
  logic [23:0] RQ_EXT_ADDR;
  logic [23:0] RQ_TX_DATA;
  logic [7:0]  RQ_RXD;
  logic        ARB_BUSY;
  logic [2:0]  ARB_GNT;
  logic        REG_REQ;
  logic        REG_ACK;
  logic [1:0]  REG_CCD;
  logic [5:0]  REG_CPD;
  logic [7:0]  REG_EXT_ADDR;
  logic [7:0]  REG_TX_DATA;
  logic [7:0]  ULPI_DATA;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  sc_ulpi_reg_arb #(
    .NREQ    (3),
    .TIMEOUT (16)
  ) dut (
    .ULPICLK      (ULPICLK),
    .ULPIRST      (ULPIRST),
    .RQ_REQ       (RQ_REQ),
    .RQ_ACK       (RQ_ACK),
    .RQ_ERR       (RQ_ERR),
    .RQ_CCD       (RQ_CCD),
    .RQ_CPD       (RQ_CPD),
    .RQ_EXT_ADDR  (RQ_EXT_ADDR),
    .RQ_TX_DATA   (RQ_TX_DATA),
    .RQ_RXD       (RQ_RXD),
    .ARB_BUSY     (ARB_BUSY),
    .ARB_GNT      (ARB_GNT),
    .REG_REQ      (REG_REQ),
    .REG_ACK      (REG_ACK),
    .REG_CCD      (REG_CCD),
    .REG_CPD      (REG_CPD),
    .REG_EXT_ADDR (REG_EXT_ADDR),
    .REG_TX_DATA  (REG_TX_DATA),
    .ULPI_DATA    (ULPI_DATA)
  );

  always #5 ULPICLK = ~ULPICLK;

  typedef struct {
    logic [2:0] req;
    logic [1:0] ccd;
    logic [5:0] cpd;
    logic [7:0] ead;
    logic [7:0] txd;
    int         ack_dly;
    logic [7:0] udata;
    logic       drop;
    logic [2:0] gnt;
    logic [7:0] rxd;
  } vec_t;

  vec_t tbl [7];

  task automatic step();
    @(posedge ULPICLK);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Requester w gets the given fields, every other requester the inverse
  task automatic drive_fields(input logic [2:0] w, input logic [1:0] ccd, input logic [5:0] cpd,
                              input logic [7:0] ead, input logic [7:0] txd);
    for (int i = 0; i < 3; i++) begin
      if (3'(i) == w) begin
        RQ_CCD[i*2 +: 2]      = ccd;
        RQ_CPD[i*6 +: 6]      = cpd;
        RQ_EXT_ADDR[i*8 +: 8] = ead;
        RQ_TX_DATA[i*8 +: 8]  = txd;
      end else begin
        RQ_CCD[i*2 +: 2]      = ~ccd;
        RQ_CPD[i*6 +: 6]      = ~cpd;
        RQ_EXT_ADDR[i*8 +: 8] = ~ead;
        RQ_TX_DATA[i*8 +: 8]  = ~txd;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL sim_limit: got timeout want finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    int prev;
    vec_t v;

    //           req     ccd          cpd    ead    txd    dly udata  drop gnt   rxd
    tbl[0] = '{3'b010, ccdRegRead,  6'h0A, 8'h2F, 8'h11, 5,  8'h5A, 1'b0, 3'd1, 8'h5A};
    tbl[1] = '{3'b111, ccdRegWrite, 6'h04, 8'h00, 8'h45, 2,  8'hFF, 1'b0, 3'd2, 8'h5A};
    tbl[2] = '{3'b111, ccdRegRead,  6'h3F, 8'hA0, 8'h00, 1,  8'h3C, 1'b0, 3'd0, 8'h3C};
    tbl[3] = '{3'b101, ccdRegRead,  6'h21, 8'h12, 8'h77, 3,  8'hC3, 1'b0, 3'd2, 8'hC3};
    tbl[4] = '{3'b011, ccdRegWrite, 6'h16, 8'h34, 8'hB2, 4,  8'h00, 1'b0, 3'd0, 8'hC3};
    tbl[5] = '{3'b001, ccdRegRead,  6'h01, 8'h56, 8'h9E, 2,  8'h81, 1'b0, 3'd0, 8'h81};
    tbl[6] = '{3'b100, ccdRegRead,  6'h2A, 8'h78, 8'h55, 15, 8'h7E, 1'b1, 3'd2, 8'h7E};

    ULPIRST   = 1'b1;
    RQ_REQ    = '0;
    RQ_CCD    = '0;
    RQ_CPD    = '0;
    RQ_EXT_ADDR = '0;
    RQ_TX_DATA  = '0;
    REG_ACK   = 1'b0;
    ULPI_DATA = '0;
    step();
    step();

    // reset values
    chk("rst_reg_req", 32'(REG_REQ), 0);
    chk("rst_busy", 32'(ARB_BUSY), 0);
    chk("rst_gnt", 32'(ARB_GNT), 2);
    chk("rst_ack", 32'(RQ_ACK), 0);
    chk("rst_err", 32'(RQ_ERR), 0);
    chk("rst_rxd", 32'(RQ_RXD), 0);
    chk("rst_fields", 32'({REG_CCD, REG_CPD, REG_EXT_ADDR, REG_TX_DATA}), 0);
    ULPIRST = 1'b0;
    step();

    // table of single transactions
    for (int t = 0; t < 7; t++) begin
      v = tbl[t];
      RQ_REQ = v.req;
      drive_fields(v.gnt, v.ccd, v.cpd, v.ead, v.txd);
      step();
      chk($sformatf("t%0d_req_lat", t), 32'(REG_REQ), 1);
      chk($sformatf("t%0d_gnt", t), 32'(ARB_GNT), 32'(v.gnt));
      chk($sformatf("t%0d_busy", t), 32'(ARB_BUSY), 1);
      chk($sformatf("t%0d_fields", t), 32'({REG_CCD, REG_CPD, REG_EXT_ADDR, REG_TX_DATA}),
          32'({v.ccd, v.cpd, v.ead, v.txd}));
      drive_fields(3'd7, v.ccd, v.cpd, v.ead, v.txd);
      if (v.drop) RQ_REQ = '0;
      repeat (v.ack_dly - 1) step();
      chk($sformatf("t%0d_hold", t), 32'({REG_REQ, REG_CPD, REG_TX_DATA}), 32'({1'b1, v.cpd, v.txd}));
      REG_ACK   = 1'b1;
      ULPI_DATA = v.udata;
      step();
      REG_ACK = 1'b0;
      chk($sformatf("t%0d_ack", t), 32'(RQ_ACK), 32'(3'b001 << v.gnt));
      chk($sformatf("t%0d_err", t), 32'(RQ_ERR), 0);
      chk($sformatf("t%0d_rxd", t), 32'(RQ_RXD), 32'(v.rxd));
      chk($sformatf("t%0d_req_fall", t), 32'(REG_REQ), 0);
      RQ_REQ = '0;
      step();
      chk($sformatf("t%0d_done", t), 32'({ARB_BUSY, RQ_ACK}), 0);
      step();
    end

    // REG_ACK while idle is ignored
    REG_ACK   = 1'b1;
    ULPI_DATA = 8'h01;
    step();
    REG_ACK = 1'b0;
    chk("idle_ack_none", 32'({RQ_ACK, REG_REQ}), 0);
    chk("idle_ack_rxd", 32'(RQ_RXD), 32'h7E);

    // watchdog: REG_ACK never arrives (ptr=2, so requester 1 wins)
    RQ_REQ = 3'b010;
    drive_fields(3'd1, ccdRegRead, 6'h15, 8'h33, 8'h44);
    step();
    chk("to_grant", 32'({REG_REQ, ARB_GNT}), 32'({1'b1, 3'd1}));
    n = 0;
    do begin
      step();
      n++;
    end while (REG_REQ && n < 40);
`ifdef SC_ULPI_REG_ARB_TIMEOUT_EN
    chk("to_len", 32'(n), 16);
    chk("to_ack", 32'(RQ_ACK), 32'(3'b010));
    chk("to_err", 32'(RQ_ERR), 32'(3'b010));
    chk("to_rxd", 32'(RQ_RXD), 0);
    RQ_REQ = '0;
    step();
    chk("to_err_pulse", 32'({RQ_ACK, RQ_ERR}), 0);
    step();
`else
    chk("noto_len", 32'(n), 40);
    chk("noto_held", 32'({REG_REQ, RQ_ACK}), 32'({1'b1, 3'b000}));
    REG_ACK   = 1'b1;
    ULPI_DATA = 8'hA5;
    step();
    REG_ACK = 1'b0;
    chk("noto_ack", 32'(RQ_ACK), 32'(3'b010));
    chk("noto_err", 32'(RQ_ERR), 0);
    chk("noto_rxd", 32'(RQ_RXD), 32'hA5);
    RQ_REQ = '0;
    step();
    step();
`endif

    // REG_ACK on the exact watchdog cycle wins (ptr=1, requester 2)
    RQ_REQ = 3'b100;
    drive_fields(3'd2, ccdRegRead, 6'h2C, 8'h01, 8'h02);
    step();
    chk("lim_grant", 32'({REG_REQ, ARB_GNT}), 32'({1'b1, 3'd2}));
    repeat (15) step();
    chk("lim_held", 32'(REG_REQ), 1);
    REG_ACK   = 1'b1;
    ULPI_DATA = 8'h99;
    step();
    REG_ACK = 1'b0;
    chk("lim_ack", 32'(RQ_ACK), 32'(3'b100));
    chk("lim_err", 32'(RQ_ERR), 0);
    chk("lim_rxd", 32'(RQ_RXD), 32'h99);
    RQ_REQ = '0;
    step();
    step();

    // reset during arbWait, coinciding with a REG_ACK
    RQ_REQ = 3'b001;
    drive_fields(3'd0, ccdRegWrite, 6'h11, 8'h22, 8'h33);
    step();
    chk("mid_grant", 32'({REG_REQ, ARB_GNT}), 32'({1'b1, 3'd0}));
    step();
    step();
    ULPIRST   = 1'b1;
    REG_ACK   = 1'b1;
    ULPI_DATA = 8'h66;
    RQ_REQ    = 3'b111;
    step();
    REG_ACK = 1'b0;
    chk("mid_rst_outs", 32'({RQ_ACK, RQ_ERR, REG_REQ, ARB_BUSY}), 0);
    chk("mid_rst_gnt", 32'(ARB_GNT), 2);
    chk("mid_rst_fields", 32'({REG_CCD, REG_CPD, REG_EXT_ADDR, REG_TX_DATA}), 0);
    chk("mid_rst_rxd", 32'(RQ_RXD), 0);
    ULPIRST = 1'b0;

    // fairness: all three held high, ACK two edges after each grant edge;
    // next grant follows two edges after the ACK edge
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (!REG_REQ && n < 8) begin
        step();
        n++;
      end
      chk($sformatf("fair%0d_seen", k), 32'(REG_REQ), 1);
      chk($sformatf("fair%0d_gnt", k), 32'(ARB_GNT), 32'(k % 3));
      if (k > 0) chk($sformatf("fair%0d_spacing", k), 32'(cyc - prev), 4);
      prev = cyc;
      step();
      REG_ACK   = 1'b1;
      ULPI_DATA = 8'(k);
      step();
      REG_ACK = 1'b0;
      chk($sformatf("fair%0d_ack", k), 32'(RQ_ACK), 32'(3'b001 << (k % 3)));
    end
    RQ_REQ = '0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/sc_ulpi_reg_arb.md
# sc_ulpi_reg_arb

Round-robin arbiter that shares the single ULPI register interface (REG_REQ/REG_ACK, command code, address, TX data, read data) among several register-access requesters. Typical requesters are the register access controller, a PHY init sequencer and a debug port. The block sits between those requesters and the ULPI controller. It serialises accesses, latches each granted request's fields, and returns the read data. A watchdog aborts accesses that the ULPI controller never acknowledges.

## Interface
Parameters:
- NREQ, 3, number of requesters (2..8)
- TIMEOUT, 1023, REG_ACK watchdog limit in ULPICLK cycles (1..65535)

Ports:
- ULPICLK  in  1  ULPI 60 MHz clock; the only clock
- ULPIRST  in  1  reset; synchronous, active-high
- RQ_REQ  in  NREQ  per-requester level request
- RQ_ACK  out  NREQ  per-requester one-cycle completion pulse
- RQ_ERR  out  NREQ  timeout flag; valid with RQ_ACK
- RQ_CCD  in  NREQ x 2  command code per requester
- RQ_CPD  in  NREQ x 6  register address per requester
- RQ_EXT_ADDR  in  NREQ x 8  extended address per requester
- RQ_TX_DATA  in  NREQ x 8  write data per requester
- RQ_RXD  out  8  read data; shared by all requesters; valid with RQ_ACK
- ARB_BUSY  out  1  grant active
- ARB_GNT  out  3  index of the current or last grant
- REG_REQ  out  1  request to the ULPI controller
- REG_ACK  in  1  completion pulse from the ULPI controller
- REG_CCD  out  2  latched command code
- REG_CPD  out  6  latched register address
- REG_EXT_ADDR  out  8  latched extended address
- REG_TX_DATA  out  8  latched write data
- ULPI_DATA  in  8  read data from the ULPI controller; valid with REG_ACK

## Operation
The state machine has three states: arbIdle, arbWait and arbDone.

- **arbIdle:**
  - When any RQ_REQ bit is set, pick the winner by round-robin, starting at ptr+1 and wrapping modulo NREQ.
  - Latch the winner's CCD, CPD, EXT_ADDR and TX_DATA into the REG_* registers.
  - Set ptr to the winner and ARB_GNT to the winner.
  - Assert REG_REQ and ARB_BUSY, clear the watchdog, and go to arbWait.
- **arbWait:**
  - Hold REG_REQ and the latched fields stable.
  - The winner's RQ_* inputs are not re-sampled; changes to them are ignored.
  - On REG_ACK:
    - Drop REG_REQ.
    - Pulse RQ_ACK[gnt]; RQ_ERR[gnt] is 0.
    - RQ_RXD takes ULPI_DATA if REG_CCD equals ccdRegRead; otherwise it keeps its previous value.
    - Go to arbDone.
- **Timeout:** when the watchdog reaches TIMEOUT with no REG_ACK:
  - Drop REG_REQ.
  - Pulse RQ_ACK[gnt] with RQ_ERR[gnt]=1 and RQ_RXD=0.
  - Go to arbDone.
- **arbDone:**
  - Lasts one cycle; ARB_BUSY is deasserted on exit.
  - Go to arbIdle.
  - This cycle gives the acknowledged requester time to drop RQ_REQ before arbitration resumes.

Rules and boundary conditions:
- **Requester handshake:** a requester holds RQ_REQ high until it sees RQ_ACK, then drops it on the next edge. If RQ_REQ is still high when arbitration resumes in arbIdle, that is a new request.
- **Simultaneous requests:** resolved by the pointer. The requester just served has the lowest priority, so no requester can starve another.
- **REG_ACK outside arbWait:** ignored.
- **REG_ACK on the same cycle as the timeout:** the ACK wins; RQ_ERR=0.
- **Request dropped during arbWait:** the access still completes and RQ_ACK still pulses.
- **Reset values:**
  - Outputs: RQ_ACK, RQ_ERR, RQ_RXD, ARB_BUSY, REG_REQ, REG_CCD, REG_CPD, REG_EXT_ADDR and REG_TX_DATA are all 0.
  - ARB_GNT resets to NREQ-1.
  - Internal: ptr resets to NREQ-1, so requester 0 wins the first tie. The state resets to arbIdle.
- **Reset mid-access:** applied on the next edge, with no ACK to the requester.
- **Watchdog width:** the counter is $clog2(TIMEOUT+1) bits wide and saturates.

## Timing
- RQ_REQ is sampled in arbIdle at edge N; REG_REQ is high from edge N+1. Grant latency is 1 cycle.
- REG_ACK is sampled at edge M; REG_REQ falls and RQ_ACK/RQ_RXD are valid at edge M+1, so completion latency is 1 cycle.
- The arbiter returns to arbIdle at edge M+2. The next REG_REQ rises at M+3 at the earliest.
- Minimum spacing between two back-to-back grants is 3 cycles plus the ULPI access time.
- A timeout fires with REG_REQ having been high for exactly TIMEOUT cycles.

## Configuration
- Macro: SC_ULPI_REG_ARB_TIMEOUT_EN.
- Defined: the watchdog is built as described; RQ_ERR can assert.
- Undefined: no counter is built; arbWait waits for REG_ACK indefinitely; RQ_ERR is tied to 0; the TIMEOUT parameter is unused.

## Structure
- Add to sc_ulpi_pkg:
  - the arbState_e enum (arbIdle, arbWait, arbDone);
  - the ulpiRegReq_s struct (ccd, cpd, ead, txd);
  - the constant ARB_TIMEOUT_DEFAULT = 1023.
- Reuse the existing ccdRegRead/ccdRegWrite codes from sc_ulpi_pkg.
- One sub-module, sc_ulpi_rr_pick: a combinational round-robin picker. Inputs are the request vector and ptr; outputs are a valid flag and the winner index.

## Test plan
- **Single requester:** RQ_REQ[1]=1 with CCD=read, CPD=6'h0A; REG_ACK after 5 cycles with ULPI_DATA=8'h5A. Expect REG_REQ at +1, REG_CPD=6'h0A, RQ_ACK[1] pulse with RQ_RXD=8'h5A and RQ_ERR=0.
- **Fairness:** all three requests held high continuously with REG_ACK 2 cycles after each REG_REQ. Grants must follow 0,1,2,0,1,2, with a 3-cycle minimum gap between grants.
- **Write access:** CCD=write, TX_DATA=8'h45; REG_ACK with ULPI_DATA=8'hFF. Expect REG_TX_DATA=8'h45 and RQ_RXD unchanged from its previous value.
- **Timeout:** TIMEOUT=16 and REG_ACK never asserts. REG_REQ falls after 16 cycles; RQ_ACK pulses with RQ_ERR=1 and RQ_RXD=0. Run twice: macro defined, then undefined (no timeout).
- **Ack at the limit:** REG_ACK arrives on the exact timeout cycle. Expect RQ_ERR=0 and valid RQ_RXD.
- **Reset mid-access:** ULPIRST pulsed during arbWait. On the next edge all outputs take their reset values and no RQ_ACK is issued; afterwards requester 0 wins a 3-way tie.
